hazard_stall_ctrl: RTL and testbench

Central stall/flush sequencer for the 5-stage pipeline. It detects load-use hazards and drives the hazard-select input of the ID-stage control-zeroing mux. It also gates PC and IF/ID writes, flushes IF/ID on taken branches/jumps, and freezes the whole pipeline through a data-cache miss using a small FSM with a miss watchdog. It sits beside the ID stage and takes inputs from the ID/EX register and the data-cache controller.

---
 rtl/hazard_pkg.sv | 18 +
 rtl/load_use_detect.sv | 14 +
 rtl/hazard_stall_ctrl.sv | 151 +++++++++++++++
 tb/tb_hazard_stall_ctrl.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
package hazard_pkg;

    typedef enum logic [0:0] {
        RUN       = 1'b0,
        MISS_WAIT = 1'b1
    } state_e;

    localparam logic [4:0] REG_ZERO         = 5'd0;
    localparam int         MISS_TIMEOUT_DEF = 1024;
    localparam int         WD_W             = 16;

    // $zero never carries a real dependency, so it never matches.
    function automatic logic reg_match(input logic [4:0] dst, input logic [4:0] src);
        return (dst != REG_ZERO) && (dst == src);
    endfunction

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use comparator: the load in EX writes a register that the ID instruction reads.
module load_use_detect
    import hazard_pkg::*;
(
    input  logic       mem_read,
    input  logic [4:0] ex_rt,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    output logic       hazard
);

    assign hazard = mem_read & (reg_match(ex_rt, id_rs) | reg_match(ex_rt, id_rt));

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Stall/flush sequencer: load-use bubbles, branch flushes, D-cache miss freeze with watchdog.
// Optional perf counters are built when STALL_CTRL_PERF_EN is defined.
module hazard_stall_ctrl
    import hazard_pkg::*;
#(
    parameter int MISS_TIMEOUT = MISS_TIMEOUT_DEF,
    parameter int CNT_W        = 32
)
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             IDEX_MemRead_i,
    input  logic [4:0]       IDEX_RegRt_i,
    input  logic [4:0]       IFID_RegRs_i,
    input  logic [4:0]       IFID_RegRt_i,
    input  logic             BranchTaken_i,
    input  logic             DCacheReq_i,
    input  logic             DCacheAck_i,
    output logic             PCWrite_o,
    output logic             IFIDWrite_o,
    output logic             IsHazzard_o,
    output logic             IFIDFlush_o,
    output logic             PipeStall_o,
    output logic             Timeout_o,
    output logic [CNT_W-1:0] BubbleCnt_o,
    output logic [CNT_W-1:0] FreezeCnt_o,
    output logic [CNT_W-1:0] FlushCnt_o
);

    localparam logic [WD_W-1:0] TIMEOUT_VAL = WD_W'(MISS_TIMEOUT);

    state_e          state_r;
    logic [WD_W-1:0] wd_r;
    logic            timeout_r;
    logic            lu_s;
    logic            freeze_s;

    load_use_detect u_lu (
        .mem_read (IDEX_MemRead_i),
        .ex_rt    (IDEX_RegRt_i),
        .id_rs    (IFID_RegRs_i),
        .id_rt    (IFID_RegRt_i),
        .hazard   (lu_s)
    );

    // Ack is only meaningful while a miss is outstanding or being raised.
    assign freeze_s = ((state_r == RUN) & DCacheReq_i & ~DCacheAck_i)
                    | ((state_r == MISS_WAIT) & ~DCacheAck_i);

    // Zero-latency enable/flush/stall decode; freeze beats bubble, bubble beats flush.
    always_comb begin
        PCWrite_o   = 1'b0;
        IFIDWrite_o = 1'b0;
        IsHazzard_o = 1'b0;
        IFIDFlush_o = 1'b0;
        PipeStall_o = 1'b0;
        if (!rst_i) begin
            PCWrite_o = 1'b0;
        end else if (freeze_s) begin
            PipeStall_o = 1'b1;
        end else if (lu_s) begin
            IsHazzard_o = 1'b1;
        end else if (BranchTaken_i) begin
            IFIDFlush_o = 1'b1;
            PCWrite_o   = 1'b1;
            IFIDWrite_o = 1'b1;
        end else begin
            PCWrite_o   = 1'b1;
            IFIDWrite_o = 1'b1;
        end
    end

    // Miss FSM with saturating watchdog and sticky timeout flag.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_r   <= RUN;
            wd_r      <= {WD_W{1'b0}};
            timeout_r <= 1'b0;
        end else begin
            case (state_r)
                RUN: begin
                    if (DCacheReq_i && !DCacheAck_i) begin
                        state_r <= MISS_WAIT;
                        wd_r    <= {{(WD_W-1){1'b0}}, 1'b1};
                    end else begin
                        state_r <= RUN;
                        wd_r    <= {WD_W{1'b0}};
                    end
                end
                MISS_WAIT: begin
                    if (DCacheAck_i) begin
                        state_r <= RUN;
                        wd_r    <= {WD_W{1'b0}};
                    end else begin
                        state_r <= MISS_WAIT;
                        if (wd_r != TIMEOUT_VAL) begin
                            wd_r <= wd_r + {{(WD_W-1){1'b0}}, 1'b1};
                        end
                        if (wd_r == (TIMEOUT_VAL - {{(WD_W-1){1'b0}}, 1'b1})) begin
                            timeout_r <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_r <= RUN;
                    wd_r    <= {WD_W{1'b0}};
                end
            endcase
        end
    end

    assign Timeout_o = timeout_r;

`ifdef STALL_CTRL_PERF_EN
    logic [CNT_W-1:0] bubble_cnt_r;
    logic [CNT_W-1:0] freeze_cnt_r;
    logic [CNT_W-1:0] flush_cnt_r;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    // Saturating event counters, one step per cycle the event is active.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            bubble_cnt_r <= {CNT_W{1'b0}};
            freeze_cnt_r <= {CNT_W{1'b0}};
            flush_cnt_r  <= {CNT_W{1'b0}};
        end else begin
            if (IsHazzard_o) begin
                bubble_cnt_r <= sat_inc(bubble_cnt_r);
            end
            if (PipeStall_o) begin
                freeze_cnt_r <= sat_inc(freeze_cnt_r);
            end
            if (IFIDFlush_o) begin
                flush_cnt_r <= sat_inc(flush_cnt_r);
            end
        end
    end

    assign BubbleCnt_o = bubble_cnt_r;
    assign FreezeCnt_o = freeze_cnt_r;
    assign FlushCnt_o  = flush_cnt_r;
`else
    assign BubbleCnt_o = {CNT_W{1'b0}};
    assign FreezeCnt_o = {CNT_W{1'b0}};
    assign FlushCnt_o  = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Table-driven, scoreboarded bench for hazard_stall_ctrl (watchdog limit 4).
module tb_hazard_stall_ctrl;

    localparam int CNT_W = 32;
`ifdef STALL_CTRL_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    // Expected output vector order: {PCWrite, IFIDWrite, IsHazzard, IFIDFlush, PipeStall}
    localparam logic [4:0] E_NONE  = 5'b00000;
    localparam logic [4:0] E_RUN   = 5'b11000;
    localparam logic [4:0] E_BUB   = 5'b00100;
    localparam logic [4:0] E_FLUSH = 5'b11010;
    localparam logic [4:0] E_STALL = 5'b00001;

    typedef struct {
        string      name;
        logic       mr;
        logic [4:0] ex_rt;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       br;
        logic       req;
        logic       ack;
        logic [4:0] exp;
    } vec_t;

    typedef struct {
        string            name;
        logic [4:0]       outs;
        logic             tmo;
        logic [CNT_W-1:0] bub;
        logic [CNT_W-1:0] frz;
        logic [CNT_W-1:0] fl;
    } exp_t;

    logic             clk;
    logic             rst_i;
    logic             mem_read;
    logic [4:0]       ex_rt;
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             branch;
    logic             dreq;
    logic             dack;
    logic             pc_write;
    logic             ifid_write;
    logic             is_hazard;
    logic             ifid_flush;
    logic             pipe_stall;
    logic             timeout;
    logic [CNT_W-1:0] bubble_cnt;
    logic [CNT_W-1:0] freeze_cnt;
    logic [CNT_W-1:0] flush_cnt;

    int               n_cmp;
    int               n_fail;
    logic             exp_tmo;
    int               cnt_bub;
    int               cnt_frz;
    int               cnt_fl;
    exp_t             sb_q[$];
    vec_t             tbl[13];

    hazard_stall_ctrl #(.MISS_TIMEOUT(4), .CNT_W(CNT_W)) dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .IDEX_MemRead_i (mem_read),
        .IDEX_RegRt_i   (ex_rt),
        .IFID_RegRs_i   (id_rs),
        .IFID_RegRt_i   (id_rt),
        .BranchTaken_i  (branch),
        .DCacheReq_i    (dreq),
        .DCacheAck_i    (dack),
        .PCWrite_o      (pc_write),
        .IFIDWrite_o    (ifid_write),
        .IsHazzard_o    (is_hazard),
        .IFIDFlush_o    (ifid_flush),
        .PipeStall_o    (pipe_stall),
        .Timeout_o      (timeout),
        .BubbleCnt_o    (bubble_cnt),
        .FreezeCnt_o    (freeze_cnt),
        .FlushCnt_o     (flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input string nm, input logic m, input logic [4:0] xr,
                                input logic [4:0] s, input logic [4:0] t, input logic b,
                                input logic rq, input logic ak, input logic [4:0] e);
        vec_t v;
        v.name = nm; v.mr = m; v.ex_rt = xr; v.rs = s; v.rt = t;
        v.br = b; v.req = rq; v.ack = ak; v.exp = e;
        return v;
    endfunction

    task automatic cmp(input string nm, input string what, input logic [CNT_W-1:0] act,
                       input logic [CNT_W-1:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s/%s: got %0h required %0h", nm, what, act, req);
        end
    endtask

    task automatic check_front();
        exp_t e;
        if (sb_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL scoreboard: empty queue at sample");
        end else begin
            e = sb_q.pop_front();
            cmp(e.name, "outs", CNT_W'({pc_write, ifid_write, is_hazard, ifid_flush, pipe_stall}),
                CNT_W'(e.outs));
            cmp(e.name, "timeout", CNT_W'(timeout), CNT_W'(e.tmo));
            cmp(e.name, "bubble_cnt", bubble_cnt, e.bub);
            cmp(e.name, "freeze_cnt", freeze_cnt, e.frz);
            cmp(e.name, "flush_cnt", flush_cnt, e.fl);
        end
    endtask

    // Drive one cycle of stimulus, queue its expectation, sample on the falling edge.
    task automatic apply(input vec_t v);
        exp_t e;
        mem_read = v.mr; ex_rt = v.ex_rt; id_rs = v.rs; id_rt = v.rt;
        branch = v.br; dreq = v.req; dack = v.ack;
        e.name = v.name;
        e.outs = v.exp;
        e.tmo  = exp_tmo;
        e.bub  = PERF ? CNT_W'(cnt_bub) : {CNT_W{1'b0}};
        e.frz  = PERF ? CNT_W'(cnt_frz) : {CNT_W{1'b0}};
        e.fl   = PERF ? CNT_W'(cnt_fl)  : {CNT_W{1'b0}};
        sb_q.push_back(e);
        if (v.exp[2]) cnt_bub++;
        if (v.exp[1]) cnt_fl++;
        if (v.exp[0]) cnt_frz++;
        @(negedge clk);
        check_front();
        @(posedge clk);
        #1;
    endtask

    // Hold reset for one cycle with hazard/branch/miss inputs active; everything must read 0.
    task automatic do_reset();
        rst_i   = 1'b0;
        exp_tmo = 1'b0;
        cnt_bub = 0; cnt_frz = 0; cnt_fl = 0;
        apply(mk("rst_hold", 1'b1, 5'd8, 5'd8, 5'd0, 1'b1, 1'b1, 1'b0, E_NONE));
        rst_i = 1'b1;
    endtask

    initial begin
        n_cmp = 0; n_fail = 0; exp_tmo = 1'b0;
        cnt_bub = 0; cnt_frz = 0; cnt_fl = 0;
        rst_i = 1'b0; mem_read = 1'b0; ex_rt = 5'd0; id_rs = 5'd0; id_rt = 5'd0;
        branch = 1'b0; dreq = 1'b0; dack = 1'b0;

        tbl[0]  = mk("idle",         1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, E_RUN);
        tbl[1]  = mk("lu_rs",        1'b1, 5'd8,  5'd8,  5'd3,  1'b0, 1'b0, 1'b0, E_BUB);
        tbl[2]  = mk("lu_drop",      1'b0, 5'd8,  5'd8,  5'd3,  1'b0, 1'b0, 1'b0, E_RUN);
        tbl[3]  = mk("lu_rt",        1'b1, 5'd12, 5'd1,  5'd12, 1'b0, 1'b0, 1'b0, E_BUB);
        tbl[4]  = mk("lu_zero_reg",  1'b1, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, E_RUN);
        tbl[5]  = mk("load_nomatch", 1'b1, 5'd5,  5'd6,  5'd7,  1'b0, 1'b0, 1'b0, E_RUN);
        tbl[6]  = mk("branch",       1'b0, 5'd0,  5'd4,  5'd4,  1'b1, 1'b0, 1'b0, E_FLUSH);
        tbl[7]  = mk("branch_lu",    1'b1, 5'd9,  5'd9,  5'd2,  1'b1, 1'b0, 1'b0, E_BUB);
        tbl[8]  = mk("stray_ack",    1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b1, E_RUN);
        tbl[9]  = mk("zero_wait",    1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 1'b1, 1'b1, E_RUN);
        tbl[10] = mk("after_zw",     1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, E_RUN);
        tbl[11] = mk("zw_lu",        1'b1, 5'd31, 5'd2,  5'd31, 1'b0, 1'b1, 1'b1, E_BUB);
        tbl[12] = mk("zw_branch",    1'b0, 5'd31, 5'd31, 5'd31, 1'b1, 1'b1, 1'b1, E_FLUSH);

        @(posedge clk);
        #1;
        do_reset();

        for (int i = 0; i < 13; i++) begin
            apply(tbl[i]);
        end

        // Four-cycle miss: freeze through the wait, ack cycle follows branch rule.
        do_reset();
        apply(mk("miss_req",   1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, E_STALL));
        apply(mk("miss_w_lu",  1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b1, 1'b0, E_STALL));
        apply(mk("miss_w_br",  1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, E_STALL));
        apply(mk("miss_w3",    1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, E_STALL));
        exp_tmo = 1'b1;
        apply(mk("miss_ack",   1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, E_FLUSH));
        apply(mk("miss_after", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, E_RUN));

        // Watchdog with no ack, then reset in the middle of the miss.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            apply(mk("wd_wait", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, E_STALL));
        end
        exp_tmo = 1'b1;
        apply(mk("wd_tmo",    1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, E_STALL));
        apply(mk("wd_sticky", 1'b1, 5'd3, 5'd3, 5'd3, 1'b1, 1'b1, 1'b0, E_STALL));
        do_reset();
        apply(mk("post_rst",  1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, E_RUN));
        apply(mk("post_lu",   1'b1, 5'd7, 5'd0, 5'd7, 1'b0, 1'b0, 1'b0, E_BUB));
        apply(mk("post_miss", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, E_STALL));
        apply(mk("post_ack",  1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, E_RUN));

        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard: %0d entries left, required 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
